wb_mem_target: RTL
==================

# wb_mem_target

Wishbone classic-cycle responder that terminates one target port of the Wishbone NxN interconnect (`TADR`/`TDAT_W`/… slice). It backs a word-addressed memory with byte-lane write enables and answers each `CYC`&`STB` request with a single-cycle `ACK` (or `ERR`) after a configurable number of wait states. It is the generic memory/scratchpad target hung off the interconnect in the firmware payload.

## Interface
- `WB_ADDR_WIDTH`, 32, address width (byte address)
- `WB_DATA_WIDTH`, 32, data width; multiple of 8
- `DEPTH`, 256, memory depth in words; power of two, ≥2
- `WAIT_STATES`, 0, cycles inserted between request capture and `ACK`/`ERR`; 0..15
- `BASE_ADR`, 32'h2800_0000, byte base address; aligned to `DEPTH*WB_DATA_WIDTH/8`

Clock/reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `ADR`  in  WB_ADDR_WIDTH  byte address
- `DAT_W`  in  WB_DATA_WIDTH  write data
- `DAT_R`  out  WB_DATA_WIDTH  read data, valid only with `ACK`
- `CYC`  in  1  bus cycle
- `STB`  in  1  strobe
- `SEL`  in  WB_DATA_WIDTH/8  byte-lane select
- `WE`  in  1  1 = write
- `ACK`  out  1  normal termination, one-cycle pulse
- `ERR`  out  1  error termination, one-cycle pulse

## Operation
- Word index = `ADR[LSB +: AW]`, `LSB = $clog2(WB_DATA_WIDTH/8)`, `AW = $clog2(DEPTH)`.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on `CYC&STB` capture `ADR`,`DAT_W`,`SEL`,`WE`, hit flag; go WAIT if `WAIT_STATES>0` (load counter to `WAIT_STATES-1`), else RESP.
  - WAIT: decrement counter; at 0 go RESP. If `CYC==0` → IDLE, no memory update, no termination (abort).
  - RESP: assert exactly one of `ACK`/`ERR` for one cycle; write commits on this edge for byte lanes with `SEL[i]=1`; read data driven on `DAT_R`. Next state always IDLE.
- Mandatory IDLE cycle after every termination: `ACK`/`ERR` never high on consecutive cycles; a still-asserted `STB` after termination is treated as a new request.
- Captured request fields are used; changes on `ADR`/`DAT_W`/`SEL` after capture are ignored.
- `SEL==0` write: acked, memory unchanged. `SEL` ignored for reads (full word returned).
- Memory contents not reset; outputs are.

## Timing
- Reset values: `ACK=0`, `ERR=0`, `DAT_R=0`, state IDLE, counter 0.
- Request sampled at edge t → `ACK`/`ERR` high during cycle t+1+`WAIT_STATES` (registered); 1 cycle min latency.
- `DAT_R` = 0 whenever `ACK=0`; equals addressed word (pre-write value irrelevant: reads never write) during `ACK`.
- Back-to-back throughput: one transfer per `WAIT_STATES+2` cycles.
- `rst` mid-transfer: FSM to IDLE next edge, pending write dropped, no termination emitted.
- `CYC` dropping in RESP cycle: termination still pulses; write still commits.

## Configuration
- `WB_MEM_TARGET_ERR_EN` defined: hit = `(ADR & ~(DEPTH*WB_DATA_WIDTH/8-1)) == BASE_ADR`; miss → `ERR` in RESP instead of `ACK`, no write, `DAT_R=0`.
- Undefined: upper address bits ignored, all accesses alias into memory and terminate with `ACK`; `ERR` tied 0.

## Structure
- Package `wb_pkg`: FSM state enum (`WB_TGT_IDLE`, `WB_TGT_WAIT`, `WB_TGT_RESP`), localparams for `LSB`/`AW` derivation helpers.
- Sub-module `wb_mem_target_ram`: single-port synchronous RAM, per-byte write enables, registered read; isolates memory for later SRAM macro swap.

## Test plan
- Write `ADR=BASE+0x10`, `DAT_W=0xDEADBEEF`, `SEL=4'hF`, `WAIT_STATES=0` → `ACK` one cycle after capture; readback of same address returns `0xDEADBEEF` with `ACK`.
- Byte write `SEL=4'b0100`, `DAT_W=0x00AA0000` over `0xDEADBEEF` → readback `0xDEAABEEF`.
- `WAIT_STATES=3`, read → `ACK` exactly 4 cycles after capture; `DAT_R=0` all other cycles; `STB` held high afterwards → next `ACK` 5 cycles later (IDLE gap).
- `CYC` deasserted in WAIT during write of `0x12345678` → no `ACK`/`ERR`; readback shows old value.
- With `WB_MEM_TARGET_ERR_EN`, write `ADR=0x3000_0000` → `ERR` pulse, `ACK=0`, memory unchanged; without macro same access `ACK`s and aliases to word 0.
- `rst` asserted during WAIT → `ACK=ERR=DAT_R=0` next cycle, pending write dropped, next request served normally.

Source files
------------

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone memory target:
//   - wb_tgt_state_e : responder FSM state encoding (IDLE / WAIT / RESP)
//   - WB_TGT_CNT_W   : width of the wait-state down-counter (0..15 wait states)
//   - wb_lsb()/wb_aw(): derive the byte-offset width and the word-index width
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        WB_TGT_IDLE = 2'd0,
        WB_TGT_WAIT = 2'd1,
        WB_TGT_RESP = 2'd2
    } wb_tgt_state_e;

    localparam int WB_TGT_CNT_W = 4;

    // Number of address bits that select a byte inside one data word.
    function automatic int wb_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Number of address bits that select a word inside the memory.
    function automatic int wb_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/wb_mem_target_if.sv
// -----------------------------------------------------------------------------
// wb_mem_target_if
// Wishbone classic-cycle bus bundle for one target port.
//   ADR   master->slave  byte address
//   DAT_W master->slave  write data
//   SEL   master->slave  byte-lane select
//   WE    master->slave  1 = write
//   CYC   master->slave  bus cycle
//   STB   master->slave  strobe
//   DAT_R slave->master  read data (valid only with ACK)
//   ACK   slave->master  normal termination pulse
//   ERR   slave->master  error termination pulse
// -----------------------------------------------------------------------------
interface wb_mem_target_if #(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32
) ();

    logic [WB_ADDR_WIDTH-1:0]   ADR;
    logic [WB_DATA_WIDTH-1:0]   DAT_W;
    logic [WB_DATA_WIDTH-1:0]   DAT_R;
    logic [WB_DATA_WIDTH/8-1:0] SEL;
    logic                       WE;
    logic                       CYC;
    logic                       STB;
    logic                       ACK;
    logic                       ERR;

    modport master (
        output ADR, DAT_W, SEL, WE, CYC, STB,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, SEL, WE, CYC, STB,
        output DAT_R, ACK, ERR
    );

endinterface

// File: rtl/wb_mem_target_ram.sv
// -----------------------------------------------------------------------------
// wb_mem_target_ram
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. Kept in its own module so it can be replaced by an SRAM macro.
// Contents are not reset.
//   clk    in   clock
//   wr_en  in   write strobe (bytes with wsel[i]=1 are written)
//   rd_en  in   read strobe (rdata updated on the next edge)
//   addr   in   word index
//   wdata  in   write data
//   wsel   in   byte-lane write enables
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module wb_mem_target_ram #(
    parameter int DW    = 32,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wsel,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem_r [2**AW];
    logic [DW-1:0] rdata_r;

    // Byte-lane write port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DW / 8; i++) begin
            if (wr_en && wsel[i]) begin
                mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/wb_mem_target.sv
// -----------------------------------------------------------------------------
// wb_mem_target
// Wishbone classic-cycle memory responder. Each CYC&STB request is captured,
// held for WAIT_STATES cycles, then terminated by a one-cycle ACK (or ERR).
// A mandatory IDLE cycle follows every termination.
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   bus  slave modport of wb_mem_target_if (ADR, DAT_W, SEL, WE, CYC, STB in;
//        DAT_R, ACK, ERR out)
// Optional feature macro: WB_MEM_TARGET_ERR_EN
//   defined   : accesses outside [BASE_ADR, BASE_ADR+DEPTH*bytes) get ERR
//   undefined : all addresses alias into the memory, ERR is held at 0
// -----------------------------------------------------------------------------
module wb_mem_target
    import wb_pkg::*;
#(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       DEPTH         = 256,
    parameter int                       WAIT_STATES   = 0,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADR      = 32'h2800_0000
) (
    input logic               clk,
    input logic               rst,
    wb_mem_target_if.slave    bus
);

    localparam int LSB = wb_lsb(WB_DATA_WIDTH);
    localparam int AW  = wb_aw(DEPTH);
    localparam int SW  = WB_DATA_WIDTH / 8;
    localparam logic [WB_ADDR_WIDTH-1:0] REGION_MASK = WB_ADDR_WIDTH'(DEPTH * SW - 1);
    localparam logic [WB_TGT_CNT_W-1:0]  CNT_LOAD    =
        (WAIT_STATES > 0) ? WB_TGT_CNT_W'(WAIT_STATES - 1) : {WB_TGT_CNT_W{1'b0}};

    wb_tgt_state_e              state_r;
    wb_tgt_state_e              state_s;
    logic [WB_TGT_CNT_W-1:0]    cnt_r;
    logic [AW-1:0]              idx_r;
    logic [WB_DATA_WIDTH-1:0]   dat_w_r;
    logic [SW-1:0]              sel_r;
    logic                       we_r;
    logic                       hit_r;
    logic                       ack_r;
    logic                       err_r;

    logic                       req_s;
    logic                       hit_s;
    logic                       resp_hit_s;
    logic                       resp_we_s;
    logic                       ack_s;
    logic                       err_s;
    logic [AW-1:0]              ram_addr_s;
    logic                       ram_rd_s;
    logic                       ram_wr_s;
    logic [WB_DATA_WIDTH-1:0]   ram_rdata_s;
    logic                       unused_s;

    assign req_s = bus.CYC & bus.STB;

`ifdef WB_MEM_TARGET_ERR_EN
    assign hit_s = ((bus.ADR & ~REGION_MASK) == BASE_ADR);
`else
    assign hit_s = 1'b1;
`endif

    // Upper address bits and the base address only matter with the error check.
    assign unused_s = ^{bus.ADR, BASE_ADR, REGION_MASK};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= WB_TGT_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic; CYC dropping during WAIT aborts the transfer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            WB_TGT_IDLE: begin
                if (req_s) begin
                    if (WAIT_STATES > 0) begin
                        state_s = WB_TGT_WAIT;
                    end else begin
                        state_s = WB_TGT_RESP;
                    end
                end else begin
                    state_s = WB_TGT_IDLE;
                end
            end
            WB_TGT_WAIT: begin
                if (!bus.CYC) begin
                    state_s = WB_TGT_IDLE;
                end else if (cnt_r == {WB_TGT_CNT_W{1'b0}}) begin
                    state_s = WB_TGT_RESP;
                end else begin
                    state_s = WB_TGT_WAIT;
                end
            end
            WB_TGT_RESP: state_s = WB_TGT_IDLE;
            default:     state_s = WB_TGT_IDLE;
        endcase
    end

    // FSM output decode: next-cycle termination and RAM strobes.
    // On the IDLE->RESP path (no wait states) the request is still on the
    // bus, so the live bus fields are used instead of the captured ones.
    always_comb begin
        ack_s      = 1'b0;
        err_s      = 1'b0;
        resp_hit_s = hit_r;
        resp_we_s  = we_r;
        ram_addr_s = idx_r;
        if (state_r == WB_TGT_IDLE) begin
            resp_hit_s = hit_s;
            resp_we_s  = bus.WE;
            ram_addr_s = bus.ADR[LSB +: AW];
        end else begin
            resp_hit_s = hit_r;
            resp_we_s  = we_r;
            ram_addr_s = idx_r;
        end
        if (state_s == WB_TGT_RESP) begin
            ack_s = resp_hit_s;
`ifdef WB_MEM_TARGET_ERR_EN
            err_s = ~resp_hit_s;
`else
            err_s = 1'b0;
`endif
        end else begin
            ack_s = 1'b0;
            err_s = 1'b0;
        end
        // Read is launched on the edge entering RESP so data lines up with ACK.
        ram_rd_s = (state_s == WB_TGT_RESP) && !resp_we_s;
        // Write commits on the edge leaving RESP; a reset on that edge drops it.
        ram_wr_s = (state_r == WB_TGT_RESP) && we_r && hit_r && !rst;
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {WB_TGT_CNT_W{1'b0}};
            idx_r   <= {AW{1'b0}};
            dat_w_r <= {WB_DATA_WIDTH{1'b0}};
            sel_r   <= {SW{1'b0}};
            we_r    <= 1'b0;
            hit_r   <= 1'b0;
        end else begin
            case (state_r)
                WB_TGT_IDLE: begin
                    if (req_s) begin
                        cnt_r   <= CNT_LOAD;
                        idx_r   <= bus.ADR[LSB +: AW];
                        dat_w_r <= bus.DAT_W;
                        sel_r   <= bus.SEL;
                        we_r    <= bus.WE;
                        hit_r   <= hit_s;
                    end
                end
                WB_TGT_WAIT: begin
                    if (cnt_r != {WB_TGT_CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(WB_TGT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Registered termination outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= ack_s;
            err_r <= err_s;
        end
    end

    wb_mem_target_ram #(
        .DW (WB_DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .wr_en (ram_wr_s),
        .rd_en (ram_rd_s),
        .addr  (ram_addr_s),
        .wdata (dat_w_r),
        .wsel  (sel_r),
        .rdata (ram_rdata_s)
    );

    assign bus.ACK   = ack_r;
    assign bus.ERR   = err_r;
    // Read data is forced to zero outside the ACK cycle.
    assign bus.DAT_R = ack_r ? ram_rdata_s : {WB_DATA_WIDTH{1'b0}};

endmodule
